shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit D-register (a bank of D flip-flops) between N_REQ requesters.
- Each requester presents write data and a request. The arbiter grants one requester at a time, and the shared register captures that requester's data.
- Sits between several producer blocks and a single shared status/data register on the STEPFPGA board.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of the shared register and of each requester's data.
- ID_W, 2, width of the owner index; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request bit per requester; bit i belongs to requester i.
- wr_data  input  N_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  output  N_REQ  one-hot grant, registered.
- owner  output  ID_W  index of the requester that last wrote the register.
- q  output  DATA_W  shared register contents.
- busy  output  1  high while in the GRANT state.

Behaviour:
- Reset: when rst is high at a rising edge, the following values apply.
  - grant=0, owner=0, q=0, busy=0.
  - State=IDLE; round-robin pointer=0, so requester 0 has highest priority.
  - This applies regardless of state; a grant in progress is abandoned and no write occurs.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select a winner by round-robin: the first set req bit searching from index ptr upward, wrapping from N_REQ-1 to 0.
  - At the edge: grant <= onehot(winner), busy <= 1, state <= GRANT.
- GRANT (exactly 1 cycle):
  - At the edge: q <= wr_data slice of the winner; owner <= winner; ptr <= (winner+1) mod N_REQ.
  - Also at the edge: grant <= 0, busy <= 0, state <= IDLE.
- Latency: req high in cycle N gives grant high in cycle N+1 and the new q value in cycle N+2.
- Throughput: at most one write every 2 cycles.
- Requester handshake:
  - Hold req high until grant[i] is seen, then deassert req from the next cycle.
  - req is not sampled for arbitration during GRANT.
  - If req is still high when the arbiter returns to IDLE, it is treated as a new request.
- Data is sampled during the GRANT cycle, not the request cycle. The requester must hold wr_data stable through its grant cycle.
- A write is committed once grant is issued. Dropping req during GRANT does not cancel the write.
- Losing requesters keep their req high; they are never dropped and are served in rotation.
- Starvation bound: a pending request is granted within 2*N_REQ cycles.
- Pointer wrap: after requester N_REQ-1 wins, ptr=0.
- grant is always one-hot or zero. owner is unchanged between writes.

Optional Feature:
- Macro: SHARED_REG_LOCK_EN.
- When defined, the block adds port lock (input, N_REQ) and parameter LOCK_MAX (default 16).
  - In GRANT, if lock[winner]=1, the block stays in GRANT and keeps grant asserted.
  - q is written with the winner's data on every cycle that GRANT is held.
  - The block leaves GRANT when lock[winner] drops, or after LOCK_MAX consecutive GRANT cycles, whichever comes first. On leaving, ptr advances as normal.
  - The lock cycle counter resets on entry to GRANT and on rst.
- When not defined, the lock port and LOCK_MAX do not exist, and GRANT always lasts exactly 1 cycle.

Test Plan:
- Reset: assert rst for 2 cycles with req=4'b1111 → grant=0, q=8'h00, owner=0, busy=0 throughout; first grant after release goes to requester 0.
- Single request: req=4'b0100 with wr_data[23:16]=8'hA5 → grant=4'b0100 on the next cycle; q=8'hA5 and owner=2 one cycle later; busy high for exactly 1 cycle.
- Round-robin: hold req=4'b1111 with data 8'h10, 8'h21, 8'h32, 8'h43 → grants 0,1,2,3,0 on cycles 1,3,5,7,9; q follows 10,21,32,43,10; grant never has more than one bit set.
- Wrap and skip: ptr=3 (after requester 2 wins), then req=4'b0011 → requester 0 granted, then requester 1; requester 3 is never granted.
- Mid-grant reset: rst asserted in the GRANT cycle for requester 1 carrying 8'hFF → q stays at its prior value, then 0 after reset; grant=0 and ptr=0.
- With SHARED_REG_LOCK_EN and LOCK_MAX=4: requester 1 holds req and lock with wr_data incrementing each cycle → grant stays high for 4 cycles and q takes 4 successive values; then forced release, and a pending requester 2 is granted next.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter that lets N_REQ requesters take
// turns writing one shared DATA_W-bit register.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   req      request bit per requester (bit i = requester i)
//   wr_data  requester i data in bits [i*DATA_W +: DATA_W]
//   lock     (SHARED_REG_LOCK_EN only) hold grant while lock[winner] is high
//   grant    registered one-hot grant
//   owner    index of the requester that last wrote q
//   q        shared register contents
//   busy     high while in the GRANT state
//
// Optional feature macro: SHARED_REG_LOCK_EN (adds lock port and LOCK_MAX).
module shared_reg_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int ID_W   = 2
`ifdef SHARED_REG_LOCK_EN
   ,
   parameter int LOCK_MAX = 16
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] wr_data,
`ifdef SHARED_REG_LOCK_EN
   input  logic [N_REQ-1:0]        lock,
`endif
   output logic [N_REQ-1:0]        grant,
   output logic [ID_W-1:0]         owner,
   output logic [DATA_W-1:0]       q,
   output logic                    busy
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   ptr_d;
   logic [ID_W-1:0]   win_q;
   logic [ID_W-1:0]   win_d;
   logic [N_REQ-1:0]  grant_d;
   logic [ID_W-1:0]   owner_d;
   logic [DATA_W-1:0] q_d;
   logic              busy_d;

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [ID_W-1:0]    ofs;
   logic [ID_W:0]      pick_sum;
   logic [ID_W-1:0]    pick;
   logic [DATA_W-1:0]  win_data;
   logic [ID_W-1:0]    ptr_nxt;
   logic               hold;

`ifdef SHARED_REG_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   logic [CNT_W-1:0] lock_cnt_q;
   logic [CNT_W-1:0] lock_cnt_d;
   logic             lock_win;
`endif

   // Rotate requests so bit 0 is the requester at ptr; the lowest set
   // bit of the rotated vector is the round-robin winner's offset.
   always_comb begin
      req_dbl = {req, req};
      req_rot = N_REQ'(req_dbl >> ptr_q);
      ofs = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            ofs = ID_W'(k);
         end
      end
      pick_sum = {1'b0, ptr_q} + {1'b0, ofs};
      if (pick_sum >= (ID_W+1)'(N_REQ)) begin
         pick_sum = pick_sum - (ID_W+1)'(N_REQ);
      end
      pick = pick_sum[ID_W-1:0];
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_q == ID_W'(i)) begin
            win_data = wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign ptr_nxt = (win_q == ID_W'(N_REQ - 1)) ? '0
                                                : win_q + ID_W'(1);

`ifdef SHARED_REG_LOCK_EN
   always_comb begin
      lock_win = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_q == ID_W'(i)) begin
            lock_win = lock[i];
         end
      end
   end

   // Stay in GRANT while the winner holds lock, capped at LOCK_MAX
   // consecutive GRANT cycles (lock_cnt_q counts completed ones).
   assign hold = lock_win && ((int'(lock_cnt_q) + 1) < LOCK_MAX);
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      grant_d = grant;
      owner_d = owner;
      q_d     = q;
      busy_d  = busy;
`ifdef SHARED_REG_LOCK_EN
      lock_cnt_d = lock_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               win_d   = pick;
               grant_d = '0;
               for (int i = 0; i < N_REQ; i++) begin
                  if (pick == ID_W'(i)) begin
                     grant_d[i] = 1'b1;
                  end
               end
               busy_d  = 1'b1;
               state_d = GRANT;
`ifdef SHARED_REG_LOCK_EN
               lock_cnt_d = '0;
`endif
            end
         end
         GRANT: begin
            // Data is taken in the grant cycle, not the request cycle.
            q_d     = win_data;
            owner_d = win_q;
            if (hold) begin
`ifdef SHARED_REG_LOCK_EN
               lock_cnt_d = lock_cnt_q + CNT_W'(1);
`endif
            end else begin
               ptr_d   = ptr_nxt;
               grant_d = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         grant   <= '0;
         owner   <= '0;
         q       <= '0;
         busy    <= 1'b0;
`ifdef SHARED_REG_LOCK_EN
         lock_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         grant   <= grant_d;
         owner   <= owner_d;
         q       <= q_d;
         busy    <= busy_d;
`ifdef SHARED_REG_LOCK_EN
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed bench for shared_reg_arbiter.
// Linear stimulus with hand-computed expectations.
module tb_shared_reg_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] wr_data;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic [7:0]  q;
   logic        busy;
`ifdef SHARED_REG_LOCK_EN
   logic [3:0]  lock;
`endif

   int ncmp;
   int nerr;

   shared_reg_arbiter #(
      .N_REQ   (4),
      .DATA_W  (8),
      .ID_W    (2)
`ifdef SHARED_REG_LOCK_EN
      ,
      .LOCK_MAX(4)
`endif
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr_data (wr_data),
`ifdef SHARED_REG_LOCK_EN
      .lock    (lock),
`endif
      .grant   (grant),
      .owner   (owner),
      .q       (q),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag,
                          input logic [3:0] g,
                          input logic [7:0] qq,
                          input logic [1:0] o,
                          input logic b);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".q"}, 32'(q), 32'(qq));
      chk({tag, ".owner"}, 32'(owner), 32'(o));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'd1);
   endtask

   initial begin
      ncmp = 0;
      nerr = 0;
      rst = 1'b1;
      req = 4'b1111;
      wr_data = {8'h43, 8'h32, 8'h21, 8'h10};
`ifdef SHARED_REG_LOCK_EN
      lock = 4'b0000;
`endif

      // reset held 2 cycles with all requests high
      step();
      chk_all("rst1", 4'b0000, 8'h00, 2'd0, 1'b0);
      step();
      chk_all("rst2", 4'b0000, 8'h00, 2'd0, 1'b0);
      rst = 1'b0;

      // round robin, req=1111 held
      step();
      chk_all("rr0g", 4'b0001, 8'h00, 2'd0, 1'b1);
      step();
      chk_all("rr0w", 4'b0000, 8'h10, 2'd0, 1'b0);
      step();
      chk_all("rr1g", 4'b0010, 8'h10, 2'd0, 1'b1);
      step();
      chk_all("rr1w", 4'b0000, 8'h21, 2'd1, 1'b0);
      step();
      chk_all("rr2g", 4'b0100, 8'h21, 2'd1, 1'b1);
      step();
      chk_all("rr2w", 4'b0000, 8'h32, 2'd2, 1'b0);
      step();
      chk_all("rr3g", 4'b1000, 8'h32, 2'd2, 1'b1);
      step();
      chk_all("rr3w", 4'b0000, 8'h43, 2'd3, 1'b0);
      step();
      chk_all("rr4g", 4'b0001, 8'h43, 2'd3, 1'b1);
      step();
      chk_all("rr4w", 4'b0000, 8'h10, 2'd0, 1'b0);
      req = 4'b0000;
      step();
      chk_all("idle", 4'b0000, 8'h10, 2'd0, 1'b0);

      // single request from requester 2 (ptr=1)
      wr_data = {8'h43, 8'hA5, 8'h21, 8'h10};
      req = 4'b0100;
      step();
      chk_all("sg_g", 4'b0100, 8'h10, 2'd0, 1'b1);
      req = 4'b0000;
      step();
      chk_all("sg_w", 4'b0000, 8'hA5, 2'd2, 1'b0);
      step();
      chk_all("sg_h", 4'b0000, 8'hA5, 2'd2, 1'b0);

      // wrap and skip: ptr=3, req=0011
      req = 4'b0011;
      step();
      chk_all("wr0g", 4'b0001, 8'hA5, 2'd2, 1'b1);
      req = 4'b0010;
      step();
      chk_all("wr0w", 4'b0000, 8'h10, 2'd0, 1'b0);
      step();
      chk_all("wr1g", 4'b0010, 8'h10, 2'd0, 1'b1);
      req = 4'b0000;
      step();
      chk_all("wr1w", 4'b0000, 8'h21, 2'd1, 1'b0);

      // mid-grant reset, requester 1 carries FF (ptr=2)
      wr_data = {8'h43, 8'hA5, 8'hFF, 8'h10};
      req = 4'b0010;
      step();
      chk_all("mr_g", 4'b0010, 8'h21, 2'd1, 1'b1);
      rst = 1'b1;
      req = 4'b0000;
      step();
      chk_all("mr_r", 4'b0000, 8'h00, 2'd0, 1'b0);
      rst = 1'b0;
      req = 4'b1111;
      step();
      chk_all("mr_p", 4'b0001, 8'h00, 2'd0, 1'b1);
      req = 4'b0000;
      step();
      chk_all("mr_w", 4'b0000, 8'h10, 2'd0, 1'b0);

`ifdef SHARED_REG_LOCK_EN
      // lock held by requester 1, requester 2 pending (ptr=1)
      req = 4'b0110;
      lock = 4'b0010;
      step();
      chk_all("lk_g", 4'b0010, 8'h10, 2'd0, 1'b1);
      wr_data[15:8] = 8'h50;
      step();
      chk_all("lk_1", 4'b0010, 8'h50, 2'd1, 1'b1);
      wr_data[15:8] = 8'h51;
      step();
      chk_all("lk_2", 4'b0010, 8'h51, 2'd1, 1'b1);
      wr_data[15:8] = 8'h52;
      step();
      chk_all("lk_3", 4'b0010, 8'h52, 2'd1, 1'b1);
      wr_data[15:8] = 8'h53;
      step();
      chk_all("lk_4", 4'b0000, 8'h53, 2'd1, 1'b0);
      req = 4'b0100;
      lock = 4'b0000;
      step();
      chk_all("lk_n", 4'b0100, 8'h53, 2'd1, 1'b1);
      req = 4'b0000;
      step();
      chk_all("lk_w", 4'b0000, 8'hA5, 2'd2, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule
